// File: rtl/stream_mux_rr.sv
//------------------------------------------------------------------------------
// stream_mux_rr
//
// N-channel packet multiplexer with valid/ready handshakes on every input and a
// single registered output. Arbitration picks one producer per packet, either
// round-robin (search starts at the channel after the last finished packet) or
// fixed priority (lowest index wins). Once a multi-beat packet has started, the
// grant stays on that channel until its last beat has been accepted.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   mode       0 = round-robin, 1 = fixed priority; only looked at when a new
//              packet is being arbitrated
//   in_valid   per-channel beat valid                  [N]
//   in_data    channel i data in bits [i*W +: W]       [N*W]
//   in_last    per-channel end-of-packet               [N]
//   in_ready   per-channel accept, one-hot or zero     [N]
//   out_valid  output register holds a beat
//   out_data   registered beat data                    [W]
//   out_last   registered end-of-packet
//   out_sel    channel that supplied the current beat  [SELW]
//   out_ready  downstream accept
//------------------------------------------------------------------------------
module stream_mux_rr #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mode,
   input  logic [N-1:0]    in_valid,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_last,
   output logic [N-1:0]    in_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic            out_last,
   output logic [SELW-1:0] out_sel,
   input  logic            out_ready
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [SELW-1:0] lock_ch_q, lock_ch_d;

   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic [SELW-1:0] out_sel_q, out_sel_d;

   // arbitration results
   logic [SELW-1:0] rr_idx;
   logic [SELW-1:0] fp_idx;
   logic [SELW-1:0] cand;
   logic            rr_found;
   logic            any_valid;

   // handshake / selection
   logic [SELW-1:0] grant;
   logic            grant_ok;
   logic            load;
   logic            accept;
   logic [W-1:0]    sel_data;
   logic            sel_last;

   // Channel index increment with explicit wrap so that non-power-of-2 N never
   // produces an index >= N.
   function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
      if (idx == SELW'(N - 1)) begin
         return '0;
      end
      return idx + SELW'(1);
   endfunction

   //---------------------------------------------------------------------------
   // Arbitration candidates. Both winners are computed every cycle; the FSM
   // output process decides which one (if any) is used.
   //---------------------------------------------------------------------------
   always_comb begin
      rr_idx    = '0;
      rr_found  = 1'b0;
      fp_idx    = '0;
      cand      = ptr_q;
      any_valid = |in_valid;

      // Round-robin: walk ptr, ptr+1, ... with wrap; first valid wins.
      for (int k = 0; k < N; k++) begin
         if (!rr_found && in_valid[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
         cand = wrap_inc(cand);
      end

      // Fixed priority: scanning downwards leaves the lowest valid index.
      for (int k = N - 1; k >= 0; k--) begin
         if (in_valid[k]) begin
            fp_idx = SELW'(k);
         end
      end
   end

   //---------------------------------------------------------------------------
   // FSM process 1: state and output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         lock_ch_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_sel_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_ch_q   <= lock_ch_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_sel_q   <= out_sel_d;
      end
   end

   //---------------------------------------------------------------------------
   // FSM process 2: outputs of the current state (grant, ready, data select)
   //---------------------------------------------------------------------------
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;

      if (state_q == ST_LOCKED) begin
         // Mid-packet: only the locked channel may advance; others wait.
         grant    = lock_ch_q;
         grant_ok = in_valid[lock_ch_q];
      end else begin
         grant    = mode ? fp_idx : rr_idx;
         grant_ok = any_valid;
      end

      // The output register can take a beat when it is empty or being drained
      // on this same edge, which gives back-to-back transfers.
      load   = !out_valid_q || out_ready;
      // rst gates the accept so in_ready stays low for the whole reset cycle.
      accept = load && grant_ok && !rst;

      in_ready = '0;
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (SELW'(i) == grant) begin
            in_ready[i] = accept;
            sel_data    = in_data[i*W +: W];
            sel_last    = in_last[i];
         end
      end
   end

   //---------------------------------------------------------------------------
   // FSM process 3: next state, pointer, lock channel and output register
   //---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_ch_d   = lock_ch_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_sel_d   = out_sel_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_last_d  = sel_last;
         out_sel_d   = grant;

         if (sel_last) begin
            // Packet finished (single-beat packets never lock); the next
            // round-robin search starts just after this channel.
            state_d = ST_IDLE;
            ptr_d   = wrap_inc(grant);
         end else begin
            state_d   = ST_LOCKED;
            lock_ch_d = grant;
         end
      end else if (load) begin
         // Register drained or empty with nothing new: mark it empty but keep
         // data/last/sel as they were.
         out_valid_d = 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_sel   = out_sel_q;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes and a registered output. It is the sequential successor to the team's 4:1 select multiplexer: the block arbitrates among N producers in round-robin or fixed-priority mode and holds a grant for a whole packet (delimited by `last`). It presents one beat per cycle to a single downstream consumer. It sits between several packet sources and one shared sink.

## Interface
- `N`, default 4: number of input channels, N ≥ 2 (non-power-of-2 allowed).
- `W`, default 8: data width per channel, W ≥ 1.
- `SELW`, default $clog2(N): width of the channel index (derived, do not override).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only at arbitration.
- `in_valid`  in  N  per-channel beat valid.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_last`  in  N  per-channel end-of-packet flag.
- `in_ready`  out  N  per-channel accept; at most one bit high per cycle.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  registered data.
- `out_last`  out  1  registered end-of-packet flag.
- `out_sel`  out  SELW  index of the channel that supplied the current output beat.
- `out_ready`  in  1  downstream accept.

## Operation
- **Handshake.** A beat transfers on any edge where valid && ready, on both input and output sides. Inputs must hold data/last stable while valid && !ready. The block holds out_* stable while out_valid && !out_ready.
- **Load enable.** `load = !out_valid || out_ready`. The output register accepts a new beat only when load = 1.
- **Ready generation.** `in_ready[i] = load && (i == grant) && grant_ok`. All other bits are 0. Combinational paths from out_ready and in_valid to in_ready are permitted.
- **State machine:**
  - IDLE: grant = winner among in_valid.
    - mode 0: search starts at ptr and proceeds ptr, ptr+1, … N-1, 0, … (wrap).
    - mode 1: lowest index wins.
    - grant_ok = any in_valid.
    - On an accepted beat with in_last = 0, go to LOCKED with lock_ch = grant.
    - On an accepted beat with in_last = 1, stay in IDLE and set ptr = (grant+1) mod N.
  - LOCKED: grant = lock_ch and grant_ok = in_valid[lock_ch]. Other channels are ignored even if valid.
    - On an accepted beat with in_last = 1, go to IDLE and set ptr = (lock_ch+1) mod N.
- **ptr updates.** ptr updates in both modes. A mode change takes effect at the next IDLE arbitration and never breaks a lock.
- **Output register.** On an accepted beat: out_data ← channel data, out_last ← in_last, out_sel ← grant, out_valid ← 1.
- **Draining.** If load = 1 and no beat is accepted, out_valid ← 0. out_data, out_last and out_sel hold their previous values.
- **Wrap.** ptr wraps from N-1 to 0, including non-power-of-2 N. ptr never takes a value ≥ N.

## Timing
- **Reset values** (synchronous, edge with rst = 1):
  - out_valid = 0, out_data = 0, out_last = 0, out_sel = 0.
  - ptr = 0, state = IDLE.
  - in_ready = 0 throughout every cycle in which rst = 1.
- **Latency.** A beat accepted at edge t appears on out_* immediately after edge t. One register stage, one cycle.
- **Throughput.** One beat per cycle when out_ready is held at 1. There are no bubbles between packets or between channels on a switch.
- **Backpressure.** If out_ready = 0 while out_valid = 1, all in_ready = 0 in that cycle.
- **Reset mid-packet.** The lock is abandoned and state returns to IDLE with ptr = 0. Any beat in the output register is discarded.
- **Simultaneous events.** On the same edge, out_ready = 1 with out_valid = 1 and a new accepted beat gives a back-to-back transfer: out_valid stays 1 and the new data replaces the old.
- **Single-beat packets.** A beat with last = 1 and no preceding beats never enters LOCKED.

## Test plan
- **Reset.** Assert rst for 3 cycles with all in_valid = 1111 → in_ready = 0000, out_valid = 0, out_sel = 0. After release, the first grant goes to ch0.
- **Round-robin fairness.** mode = 0, N = 4, all channels send continuous single-beat packets, out_ready = 1 → out_sel sequence 0,1,2,3,0,1 with out_valid = 1 every cycle.
- **Packet lock.** ch2 sends 3 beats (last on the 3rd) while ch0 and ch1 are also valid → out_sel = 2,2,2, then 3 if valid, else the next valid channel in wrap order (0).
- **Fixed priority.** mode = 1, ch1 and ch3 continuously valid with single beats → out_sel = 1 every cycle and ch3 is starved. Switching to mode = 0 yields 3 on the next arbitration (ptr = 2).
- **Backpressure.** Hold out_ready = 0 for 4 cycles with out_data = 0xA5 → out_data stays 0xA5, all in_ready = 0. On the cycle out_ready rises, the next beat is accepted back-to-back.
- **Odd N wrap and reset mid-packet.** N = 3: ptr sequence 0,1,2,0. Assert rst during the 2nd beat of a 4-beat ch1 packet → after reset, ch0 is granted when ch0 and ch1 are both valid.
